mlaccel_xfer_ctrl: RTL and testbench
====================================

MLACCEL_XFER_CTRL -- requirements
Module: mlaccel_xfer_ctrl

Interface
REQ-001 SHALL have parameter MEM_AW, default 16: memory byte-address width.
REQ-002 SHALL have parameter LEN_W, default 8: transfer length / staging-buffer address width.
REQ-003 SHALL have port: clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: cmd_valid  input  1  command request.
REQ-006 SHALL have port: cmd_ready  output  1  command accept; high exactly when state is IDLE.
REQ-007 SHALL have port: cmd_dir  input  1  0 = upload (buffer->memory, SPI 0x23), 1 = download (memory->buffer, SPI 0x24).
REQ-008 SHALL have port: cmd_addr  input  MEM_AW  memory base byte address.
REQ-009 SHALL have port: cmd_len  input  LEN_W  byte count; 0 is a no-op.
REQ-010 SHALL have port: busy  output  1  high while state != IDLE (drives SPI status byte nonzero).
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: core_req / core_gnt  input / output  1 each  compute-core memory request/grant.
REQ-013 SHALL have port: mem_sel  output  1  1 = controller drives memory port, 0 = core does.
REQ-014 SHALL have ports: mem_addr out MEM_AW, mem_ren out 1, mem_wen out 1, mem_wdata out 8, mem_rdata in 8 (read data valid 1 cycle after mem_ren).
REQ-015 SHALL have ports: buf_addr out LEN_W, buf_wen out 1, buf_wdata out 8, buf_rdata in 8 (synchronous read, data valid 1 cycle after address).

Function
REQ-016 SHALL implement states IDLE, RD, WR, YIELD; registers base, len, dir, cnt (LEN_W), core_gnt, done.
REQ-017 IDLE: on cmd_valid, latch cmd_addr/cmd_len/cmd_dir, cnt=0; len==0 -> stay IDLE, done=1 next cycle; else -> YIELD if core_req or core_gnt, otherwise RD.
REQ-018 RD: mem_sel=1; dir=0: buf_addr=cnt; dir=1: mem_addr=base+cnt, mem_ren=1; next state WR unconditionally.
REQ-019 WR: mem_sel=1; dir=0: mem_addr=base+cnt, mem_wen=1, mem_wdata=buf_rdata; dir=1: buf_addr=cnt, buf_wen=1, buf_wdata=mem_rdata.
REQ-020 WR exit: cnt==len-1 -> IDLE with done=1 next cycle; else cnt+1 and -> YIELD if core_req, else RD.
REQ-021 Each byte SHALL take exactly 2 cycles (RD+WR); bytes never split by core access.
REQ-022 Uncontended N-byte transfer: accept at cycle 0, first RD cycle 1, last WR cycle 2N, done and cmd_ready high cycle 2N+1.
REQ-023 core_gnt SHALL be registered: set next cycle when core_req and state is IDLE or YIELD; cleared next cycle when core_req low; never 1 in RD or WR.
REQ-024 YIELD: mem_sel=0; -> RD on first cycle with core_req==0 and core_gnt==0; controller then completes at least one byte before yielding again (no starvation).
REQ-025 Same-cycle core_req and command accept: core served first (-> YIELD).
REQ-026 Memory address SHALL be (base+cnt) mod 2^MEM_AW; wraps silently past top.
REQ-027 In IDLE/YIELD all strobes (mem_ren, mem_wen, buf_wen) SHALL be 0; mem_sel=0.
REQ-028 cmd_valid outside IDLE SHALL be ignored (not queued).

Reset
REQ-029 reset high SHALL force next cycle: state IDLE, cnt=0, core_gnt=0, done=0, busy=0, all strobes 0, mem_sel=0; cmd_ready=1 the cycle after reset deasserts.
REQ-030 reset mid-transfer SHALL abort without done pulse; no write strobe after the reset edge.
REQ-031 cmd_valid during the reset cycle SHALL be ignored.

Verification
REQ-032 Upload dir=0, addr=0x0010, len=4, buf[i]=0xA0+i, core idle -> mem writes 0x10..0x13 = A0..A3 at cycles 2,4,6,8; done at cycle 9.
REQ-033 Download dir=1, addr=0xFFFE, len=4 -> memory read 0xFFFE,0xFFFF,0x0000,0x0001 into buf[0..3]; done after 9 cycles.
REQ-034 len=0 -> no strobes, busy never high, done pulse cycle 1.
REQ-035 core_req raised during byte 1 of len=3 upload, held 5 cycles -> byte 1 completes, core_gnt for 5 cycles, mem_sel=0 throughout, bytes 2-3 resume, data correct.
REQ-036 reset asserted after 2nd WR of len=8 transfer -> exactly 2 bytes written, no done, cmd_ready=1 after reset release.

Source files
------------

// File: rtl/mlaccel_xfer_ctrl.sv
// Byte-serial transfer engine between the staging buffer and accelerator memory.
// Shares the memory port with the compute core and yields to it only between bytes.
module mlaccel_xfer_ctrl #(
  parameter int MEM_AW = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  // Command handshake: a command transfers on a rising edge where cmd_valid
  // and cmd_ready are both high; cmd_ready is high only in IDLE, and a
  // cmd_valid seen while busy is dropped, not held for later.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [MEM_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  input  logic              core_req,
  output logic              core_gnt,
  output logic              mem_sel,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [LEN_W-1:0]  buf_addr,
  output logic              buf_wen,
  output logic [7:0]        buf_wdata,
  input  logic [7:0]        buf_rdata,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RD    = 2'd1;
  localparam logic [1:0] WR    = 2'd2;
  localparam logic [1:0] YIELD = 2'd3;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [1:0]        state;
  logic [MEM_AW-1:0] base;
  logic [LEN_W-1:0]  len;
  logic              dir;
  logic [LEN_W-1:0]  cnt;
  logic              last_byte;

  assign last_byte = (cnt == (len - LEN_ONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      base     <= '0;
      len      <= '0;
      dir      <= 1'b0;
      cnt      <= '0;
      core_gnt <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      // The grant can only rise where the controller is off the port, so it
      // is never seen together with RD or WR.
      core_gnt <= core_req && ((state == IDLE) || (state == YIELD));
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            base <= cmd_addr;
            len  <= cmd_len;
            dir  <= cmd_dir;
            cnt  <= '0;
            if (cmd_len == '0)
              done <= 1'b1;
            else if (core_req || core_gnt)
              state <= YIELD;
            else
              state <= RD;
          end
        end
        RD: state <= WR;
        WR: begin
          if (last_byte) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + LEN_ONE;
            state <= core_req ? YIELD : RD;
          end
        end
        YIELD: begin
          // Wait until the core has both dropped its request and seen its grant fall.
          if (!core_req && !core_gnt)
            state <= RD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RD fetches the byte from its source; WR stores it at the destination.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mem_sel   = (state == RD) || (state == WR);
  assign mem_ren   = (state == RD) && dir;
  assign mem_wen   = (state == WR) && !dir;
  assign buf_wen   = (state == WR) && dir;
  assign mem_addr  = base + MEM_AW'(cnt);
  assign mem_wdata = buf_rdata;
  assign buf_addr  = cnt;
  assign buf_wdata = mem_rdata;
  assign fsm_state = state;

endmodule

// File: tb/tb_mlaccel_xfer_ctrl.sv
// Directed bench for mlaccel_xfer_ctrl: table of transfers with hand-computed
// timing plus hand-written reset and busy-command sequences.
module tb_mlaccel_xfer_ctrl;
  localparam int MEM_AW = 16;
  localparam int LEN_W  = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [MEM_AW-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              busy;
  logic              done;
  logic              core_req;
  logic              core_gnt;
  logic              mem_sel;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic [LEN_W-1:0]  buf_addr;
  logic              buf_wen;
  logic [7:0]        buf_wdata;
  logic [7:0]        buf_rdata;
  logic [1:0]        fsm_state;

  mlaccel_xfer_ctrl #(.MEM_AW(MEM_AW), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done),
    .core_req(core_req), .core_gnt(core_gnt),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .buf_addr(buf_addr), .buf_wen(buf_wen), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- memory and buffer models ----------------
  logic [7:0] mem_m [0:65535];
  logic [7:0] buf_m [0:255];
  logic       model_init;

  function automatic logic [7:0] mem_pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] buf_pat(input logic [7:0] i);
    return 8'hA0 + i;
  endfunction

  always @(posedge clock) begin
    if (model_init) begin
      for (int i = 0; i < 65536; i++) mem_m[i] <= mem_pat(i[15:0]);
      for (int i = 0; i < 256; i++) buf_m[i] <= buf_pat(i[7:0]);
    end else begin
      if (mem_sel && mem_wen) mem_m[mem_addr] <= mem_wdata;
      if (buf_wen) buf_m[buf_addr] <= buf_wdata;
    end
    if (mem_sel && mem_ren) mem_rdata <= mem_m[mem_addr];
    buf_rdata <= buf_m[buf_addr];
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          wc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        dir;
    logic [15:0] addr;
    logic [7:0]  len;
    int          req_start;  // first cycle (0 = accept cycle) core_req is high
    int          req_hold;   // number of cycles core_req stays high
    int          exp_done;   // cycle of the done pulse
    int          exp_gnt;    // cycles with core_gnt high up to done
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  task automatic reload_models();
    @(negedge clock);
    model_init = 1'b1;
    @(negedge clock);
    model_init = 1'b0;
  endtask

  task automatic run_xfer(input vec_t v);
    int done_cyc, gnt_cnt, busy_cnt, viol, n;
    logic [15:0] ea;
    reload_models();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      if (v.dir) exp_q.push_back(mem_pat(v.addr + 16'(i)));
      else       exp_q.push_back(buf_pat(i[7:0]));
    end
    check("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_dir = v.dir; cmd_addr = v.addr; cmd_len = v.len;
    core_req  = (0 >= v.req_start) && (0 < v.req_start + v.req_hold);
    done_cyc = -1; gnt_cnt = 0; busy_cnt = 0; viol = 0;
    for (int k = 1; k <= 700 && done_cyc < 0; k++) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      core_req  = (k >= v.req_start) && (k < v.req_start + v.req_hold);
      if (core_gnt) gnt_cnt++;
      if (busy) busy_cnt++;
      if (!mem_sel && (mem_ren || mem_wen || buf_wen)) viol++;
      if (core_gnt && mem_sel) viol++;
      if (busy == cmd_ready) viol++;
      if ((!v.dir && (buf_wen || mem_ren)) || (v.dir && mem_wen)) viol++;
      if (!v.dir && mem_sel && mem_wen) begin
        wa_q.push_back(mem_addr); wd_q.push_back(mem_wdata); wc_q.push_back(k);
      end
      if (v.dir && buf_wen) begin
        wa_q.push_back(16'(buf_addr)); wd_q.push_back(buf_wdata); wc_q.push_back(k);
      end
      if (done) done_cyc = k;
    end
    core_req = 1'b0;
    check("done_cycle", done_cyc, v.exp_done);
    check("ready_at_done", cmd_ready, 1);
    check("gnt_cycles", gnt_cnt, v.exp_gnt);
    check("busy_cycles", busy_cnt, v.exp_done - 1);
    check("strobe_violations", viol, 0);
    check("write_count", wa_q.size(), v.len);
    n = (wa_q.size() < exp_q.size()) ? wa_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      ea = v.dir ? 16'(i) : (v.addr + 16'(i));
      check("write_addr", wa_q[i], ea);
      check("write_data", wd_q[i], exp_q[i]);
      if (v.req_hold == 0) check("write_cycle", wc_q[i], 2 * (i + 1));
    end
    @(negedge clock);
    check("done_one_cycle", done, 0);
    @(negedge clock);
  endtask

  // ---------------- test ----------------
  initial begin
    int wr_cnt, done_cnt, done_at, busy_late;
    logic [15:0] first_wa, second_wa;

    vecs[0] = '{1'b0, 16'h0010, 8'd4,   0, 0, 9,   0};
    vecs[1] = '{1'b1, 16'hFFFE, 8'd4,   0, 0, 9,   0};
    vecs[2] = '{1'b0, 16'h1234, 8'd0,   0, 0, 1,   0};
    vecs[3] = '{1'b0, 16'h0100, 8'd3,   2, 6, 14,  5};
    vecs[4] = '{1'b0, 16'h0200, 8'd1,   0, 2, 6,   2};
    vecs[5] = '{1'b1, 16'h0400, 8'd2,   3, 3, 5,   0};
    vecs[6] = '{1'b0, 16'hFFFF, 8'd2,   0, 0, 5,   0};
    vecs[7] = '{1'b1, 16'h8000, 8'd255, 0, 0, 511, 0};

    // Reset with a command presented during the reset cycles.
    reset = 1'b1; model_init = 1'b0; core_req = 1'b0;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_addr = 16'h0042; cmd_len = 8'd5;
    repeat (2) @(negedge clock);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_gnt", core_gnt, 0);
    check("rst_sel", mem_sel, 0);
    check("rst_strobes", {mem_ren, mem_wen, buf_wen}, 0);
    check("rst_state", fsm_state, 0);
    reset = 1'b0; cmd_valid = 1'b0;
    @(negedge clock);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", cmd_ready, 1);

    for (int t = 0; t < 8; t++) run_xfer(vecs[t]);

    // Abort an 8-byte upload right after its second write.
    reload_models();
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_addr = 16'h0500; cmd_len = 8'd8;
    wr_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (mem_sel && mem_wen) wr_cnt++;
      if (done) done_cnt++;
      if (k == 8) begin
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
      end
      cmd_valid = 1'b0;
      if (k == 5) reset = 1'b1;
      if (k == 7) reset = 1'b0;
    end
    check("abort_writes", wr_cnt, 2);
    check("abort_done", done_cnt, 0);

    // A command held while busy, with changing fields, must be neither used nor queued.
    reload_models();
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_addr = 16'h0600; cmd_len = 8'd2;
    wr_cnt = 0; done_at = -1; busy_late = 0; first_wa = '0; second_wa = '0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (mem_sel && mem_wen) begin
        if (wr_cnt == 0) first_wa = mem_addr;
        if (wr_cnt == 1) second_wa = mem_addr;
        wr_cnt++;
      end
      if (done && done_at < 0) done_at = k;
      if (k >= 6 && busy) busy_late++;
      cmd_valid = (k <= 3);
      cmd_addr  = 16'h0700;
      cmd_len   = 8'd5;
    end
    check("held_cmd_writes", wr_cnt, 2);
    check("held_cmd_addr0", first_wa, 16'h0600);
    check("held_cmd_addr1", second_wa, 16'h0601);
    check("held_cmd_done", done_at, 5);
    check("held_cmd_no_queue", busy_late, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
